// File: rtl/reg_access_master_if.sv
// Command/response handshake bundle between a requester and reg_access_master.
// The requester drives cmd_* and rsp_ready; the master side answers with cmd_ready and rsp_*.
interface reg_access_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/reg_access_master.sv
// Turns single read/write commands into register-block strobe sequences, caching the
// last accepted register number so repeat accesses skip the select/check phase.
module reg_access_master #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  reg_access_master_if.slave  bus,
  output logic [31:0]         reg_bus_o,
  output logic                reg_num_le_o,
  output logic                wr_en_o,
  output logic                rd_en_o,
  input  logic                illegal_reg_num_i,
  input  logic [31:0]         reg_rdata_i,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CHK,
    WR,
    RD,
    RWAIT,
    RSP
  } state_e;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LATENCY);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic        cache_valid_q, cache_valid_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] reg_bus_q, reg_bus_d;
  logic        reg_num_le_q, reg_num_le_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        cache_hit;

  assign cache_hit = cache_valid_q && (bus.cmd_addr == last_addr_q);

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    last_addr_d   = last_addr_q;
    cache_valid_d = cache_valid_q;
    wait_d        = wait_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          if (cache_hit) state_d = bus.cmd_write ? WR : RD;
          else           state_d = SEL;
        end
      end
      SEL: state_d = CHK;
      CHK: begin
        if (illegal_reg_num_i) begin
          cache_valid_d = 1'b0;
          rsp_error_d   = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = RSP;
        end else begin
          last_addr_d   = addr_q;
          cache_valid_d = 1'b1;
          state_d       = write_q ? WR : RD;
        end
      end
      WR: begin
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        state_d     = RSP;
      end
      RD: begin
        wait_d  = WAIT_INIT;
        state_d = RWAIT;
      end
      RWAIT: begin
        if (wait_q == 3'd1) begin
          rsp_rdata_d = reg_rdata_i;
          rsp_error_d = 1'b0;
          state_d     = RSP;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes and bus are decoded from the next state so they appear registered
    // in the very cycle the FSM occupies SEL/WR/RD.
    reg_num_le_d = (state_d == SEL);
    wr_en_d      = (state_d == WR);
    rd_en_d      = (state_d == RD);
    reg_bus_d    = '0;
    if (state_d == SEL)     reg_bus_d = addr_d;
    else if (state_d == WR) reg_bus_d = wdata_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      last_addr_q   <= '0;
      cache_valid_q <= 1'b0;
      wait_q        <= '0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      reg_bus_q     <= '0;
      reg_num_le_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      last_addr_q   <= last_addr_d;
      cache_valid_q <= cache_valid_d;
      wait_q        <= wait_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      reg_bus_q     <= reg_bus_d;
      reg_num_le_q  <= reg_num_le_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = (state_q == RSP) && !reset;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign busy_o        = (state_q != IDLE) && !reset;
  assign reg_bus_o     = reg_bus_q;
  assign reg_num_le_o  = reg_num_le_q;
  assign wr_en_o       = wr_en_q;
  assign rd_en_o       = rd_en_q;

  a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({reg_num_le_q, wr_en_q, rd_en_q}));

  a_strobe_single: assert property (@(posedge clk) disable iff (reset)
    (reg_num_le_q || wr_en_q || rd_en_q) |=> !(reg_num_le_q || wr_en_q || rd_en_q));

endmodule

// File: tb/tb_reg_access_master.sv
// Randomised bench for reg_access_master with a behavioural register-block responder
// and a transaction-level model of cache, latency and data.
module tb_reg_access_master;
  localparam int unsigned RDL  = 3;
  localparam int unsigned NREG = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reg_bus;
  logic        reg_num_le, wr_en, rd_en, illegal_reg_num, busy;
  logic [31:0] reg_rdata;

  always #4 clk = ~clk;

  reg_access_master_if bus ();

  reg_access_master #(.RD_LATENCY(RDL)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .reg_bus_o        (reg_bus),
    .reg_num_le_o     (reg_num_le),
    .wr_en_o          (wr_en),
    .rd_en_o          (rd_en),
    .illegal_reg_num_i(illegal_reg_num),
    .reg_rdata_i      (reg_rdata),
    .busy_o           (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: number latched on reg_num_le, read data valid only RDL cycles after rd_en.
  logic [31:0] rsp_mem [NREG];
  logic [31:0] num_q;
  logic [7:0]  rd_hist;
  logic        le_d1;
  logic        junk;

  always @(posedge clk) begin
    if (reset) begin
      num_q   <= '0;
      rd_hist <= '0;
      le_d1   <= 1'b0;
      for (int i = 0; i < NREG; i++) rsp_mem[i] <= '0;
    end else begin
      rd_hist <= {rd_hist[6:0], rd_en};
      le_d1   <= reg_num_le;
      if (reg_num_le) num_q <= reg_bus;
      if (wr_en && num_q < NREG) rsp_mem[num_q[4:0]] <= reg_bus;
    end
  end

  always @(negedge clk) junk <= 1'($urandom_range(0, 1));

  assign illegal_reg_num = le_d1 ? (num_q >= NREG) : junk;
  assign reg_rdata = rd_hist[RDL-1] ? rsp_mem[num_q[4:0]] : (32'hBAD0_0000 | 32'(cyc));

  // Strobe monitor
  int          le_n = 0, wr_n = 0, rd_n = 0, le_at = 0, wr_at = 0, rd_at = 0, proto_err = 0;
  logic [31:0] le_bus, wr_bus;
  logic        prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (reg_num_le) begin le_n <= le_n + 1; le_at <= cyc; le_bus <= reg_bus; end
    if (wr_en)      begin wr_n <= wr_n + 1; wr_at <= cyc; wr_bus <= reg_bus; end
    if (rd_en)      begin rd_n <= rd_n + 1; rd_at <= cyc; end
    if ((32'(reg_num_le) + 32'(wr_en) + 32'(rd_en)) > 1 ||
        (prev_strobe && (reg_num_le || wr_en || rd_en)) ||
        (!reg_num_le && !wr_en && reg_bus != '0))
      proto_err <= proto_err + 1;
    prev_strobe <= reg_num_le || wr_en || rd_en;
  end

  // Transaction-level model
  logic [31:0] m_mem [NREG];
  logic        m_cv = 1'b0;
  logic [31:0] m_last = '0;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cv   = 1'b0;
    m_last = '0;
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
  endtask

  function automatic logic [63:0] out_vec();
    return {bus.cmd_ready, bus.rsp_valid, bus.rsp_error, busy, reg_num_le, wr_en, rd_en,
            1'b0, reg_bus ^ bus.rsp_rdata, 24'h0};
  endfunction

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold);
    int          t0, le0, wr0, rd0, pe0, n, exp_lat, exp_strobe_at;
    logic        hit, ill;
    logic [31:0] exp_rdata, held_rdata;
    logic        held_err;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) begin
      check("cmd_ready_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    t0 = cyc; le0 = le_n; wr0 = wr_n; rd0 = rd_n; pe0 = proto_err;

    hit           = m_cv && (m_last == addr);
    ill           = !hit && (addr >= NREG);
    exp_lat       = ill ? 3 : ((hit ? 2 : 4) + (wr ? 0 : int'(RDL)));
    exp_strobe_at = hit ? 1 : 3;
    exp_rdata     = (ill || wr) ? '0 : m_mem[addr[4:0]];
    if (ill) m_cv = 1'b0;
    else begin
      m_cv = 1'b1; m_last = addr;
      if (wr) m_mem[addr[4:0]] = wdata;
    end

    @(negedge clk);
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    n = 1;
    while (!bus.rsp_valid && n < 60) begin @(negedge clk); n++; end
    if (!bus.rsp_valid) begin
      check("rsp_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    check("latency", 64'(cyc - t0), 64'(exp_lat));
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("rsp_error", bus.rsp_error, ill);
    check("busy_in_rsp", busy, 1);
    check("le_count", 64'(le_n - le0), hit ? 0 : 1);
    check("wr_count", 64'(wr_n - wr0), 64'(wr && !ill));
    check("rd_count", 64'(rd_n - rd0), 64'(!wr && !ill));
    check("protocol", 64'(proto_err - pe0), 0);
    if (!hit) begin
      check("le_time", 64'(le_at - t0), 1);
      check("le_bus", le_bus, addr);
    end
    if (wr && !ill) begin
      check("wr_time", 64'(wr_at - t0), 64'(exp_strobe_at));
      check("wr_bus", wr_bus, wdata);
    end
    if (!wr && !ill) check("rd_time", 64'(rd_at - t0), 64'(exp_strobe_at));

    held_rdata = bus.rsp_rdata;
    held_err   = bus.rsp_error;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_stable", {bus.rsp_valid, bus.cmd_ready, bus.rsp_error, bus.rsp_rdata},
            {1'b1, 1'b0, held_err, held_rdata});
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_release", {bus.rsp_valid, bus.cmd_ready, busy}, 3'b010);
  endtask

  task automatic abort_read(input logic [31:0] addr);
    int n;
    logic seen;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = addr;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!rd_en && n < 20) begin @(negedge clk); n++; end
    check("abort_rd_seen", rd_en, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_zero", out_vec(), 64'h0);
    check("abort_rdata", bus.rsp_rdata, 0);
    check("abort_bus", reg_bus, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("ready_after_reset", bus.cmd_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid || rd_en || wr_en || reg_num_le) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_response", seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'h0);
    check("reset_rdata", bus.rsp_rdata, 0);
    check("reset_bus", reg_bus, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.cmd_ready, 1);

    run_cmd(1'b1, 32'h2, 32'd70000, 0);       // miss write
    run_cmd(1'b0, 32'h2, 32'h0, 0);           // hit read
    run_cmd(1'b0, 32'h20, 32'h0, 0);          // illegal
    run_cmd(1'b0, 32'h2, 32'h0, 10);          // miss after invalidate, long hold
    run_cmd(1'b1, 32'h1F, 32'h0001_0203, 0);
    run_cmd(1'b0, 32'h20, 32'h0, 2);
    run_cmd(1'b0, 32'h1F, 32'h0, 0);          // miss read at RDL
    abort_read(32'h2);
    run_cmd(1'b0, 32'h2, 32'h0, 0);           // must reselect after reset

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h0;
        1:       a = 32'h1;
        2:       a = 32'h2;
        3:       a = 32'h3;
        4:       a = 32'h1F;
        5:       a = 32'h20;
        6:       a = 32'h8000_0002;
        default: a = $urandom;
      endcase
      run_cmd(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
